// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Holds the fetch FSM state enum, the buffer entry layout and PC helpers.
package imem_fetch_ctrl_pkg;

    localparam int          INSTR_W   = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_fifo.sv
// Two-entry fetch buffer; slot 0 is always the head so dout needs no read pointer.
// Flush wins over push and pop and only clears the occupancy count.
module fetch_fifo2
    import imem_fetch_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic [1:0]   count
);

    fetch_entry_t slot0;
    fetch_entry_t slot1;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign dout    = slot0;

    // Shift-style storage: a pop moves slot1 forward, a push fills the first free slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot0 <= '{pc: 32'h0, instr: NOP_INSTR};
            slot1 <= '{pc: 32'h0, instr: NOP_INSTR};
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else if (do_push && do_pop) begin
            if (count == 2'd2) begin
                slot0 <= slot1;
                slot1 <= din;
            end else begin
                slot0 <= din;
            end
        end else if (do_pop) begin
            slot0 <= slot1;
            count <= count - 2'd1;
        end else if (do_push) begin
            if (count == 2'd0) begin
                slot0 <= din;
            end else begin
                slot1 <= din;
            end
            count <= count + 2'd1;
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: PC register, BOOT/RUN/FLUSH sequencing,
// redirect handling and accepted-instruction counter around a 2-entry buffer.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] fetch_count
);

    localparam logic [1:0] FULL_COUNT = 2'(FIFO_DEPTH);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  pc;
    logic [1:0]   count;
    logic         pop;
    logic         accept;
    logic         push;
    fetch_entry_t head;
    fetch_entry_t tail_entry;
    logic         unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign if_valid   = (count != 2'd0);
    assign pop        = if_valid && if_ready;
    assign accept     = pop && !redirect_valid;
    assign tail_entry = '{pc: pc, instr: imem_instr};

    // Redirect overrides everything: no push, and the FSM (re)enters FLUSH.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        case (state)
            BOOT:  state_next = RUN;
            RUN:   push = (count < FULL_COUNT) || pop;
            FLUSH: state_next = RUN;
            default: state_next = BOOT;
        endcase
        if (redirect_valid) begin
            state_next = FLUSH;
            push       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            pc <= pc_plus4(pc);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= 32'd0;
        end else if (accept) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    fetch_fifo2 u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (accept),
        .flush (redirect_valid),
        .din   (tail_entry),
        .dout  (head),
        .count (count)
    );

    assign imem_addr   = pc;
    assign if_instr    = head.instr;
    assign if_pc       = head.pc;
    assign if_pc_plus4 = pc_plus4(head.pc);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: a vector table for the main flow
// plus directed sequences for back-pressure, chained redirects, PC wrap and mid-run reset.
module tb_imem_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] fetch_count;

    int compared;
    int mismatched;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_addr;
        logic [31:0] e_fc;
    } vec_t;

    vec_t vecs[11];

    imem_fetch_ctrl #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ROM model
    function automatic logic [31:0] rom_model(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: return 32'h2004_0003;
            32'h0000_0004: return 32'h0C00_0005;
            32'h0000_000C: return 32'h1000_FFFF;
            32'h0000_0014: return 32'h23BD_FFF8;
            default:       return addr ^ 32'hA5A5_0000;
        endcase
    endfunction

    always_comb imem_instr = rom_model(imem_addr);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
    endtask

    task automatic doReset(input logic rdy);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, rdy);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic checkHead(input string name, input logic [31:0] e_pc);
        checkOutput({name, "_valid"}, {31'd0, if_valid}, 32'd1);
        checkOutput({name, "_pc"}, if_pc, e_pc);
        checkOutput({name, "_instr"}, if_instr, rom_model(e_pc));
        checkOutput({name, "_plus4"}, if_pc_plus4, e_pc + 32'd4);
    endtask

    // Bounded wait for a head; an expired bound counts as a failed comparison
    task automatic waitValid(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (if_valid) begin
                found = 1'b1;
                break;
            end
        end
        compared++;
        if (!found) begin
            mismatched++;
            $display("[TB] FAIL %s_timeout: got if_valid 0 expected 1 within 8 cycles", name);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1);

        vecs[0]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  32'h00, 32'd0};
        vecs[1]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h0,  32'h04, 32'd0};
        vecs[2]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h4,  32'h08, 32'd1};
        vecs[3]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h8,  32'h0C, 32'd2};
        vecs[4]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h8,  32'h10, 32'd2};
        vecs[5]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h8,  32'h10, 32'd2};
        vecs[6]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'hC,  32'h14, 32'd3};
        vecs[7]  = '{1'b1, 32'h16, 1'b1, 1'b0, 32'h0,  32'h14, 32'd3};
        vecs[8]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  32'h14, 32'd3};
        vecs[9]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h14, 32'h18, 32'd3};
        vecs[10] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h18, 32'h1C, 32'd4};

        // Reset values while reset is held
        @(posedge clk);
        #1;
        checkOutput("rst_addr",   imem_addr, 32'h0);
        checkOutput("rst_valid",  {31'd0, if_valid}, 32'd0);
        checkOutput("rst_instr",  if_instr, 32'h0);
        checkOutput("rst_pc",     if_pc, 32'h0);
        checkOutput("rst_plus4",  if_pc_plus4, 32'h4);
        checkOutput("rst_fcount", fetch_count, 32'h0);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].e_valid});
            checkOutput($sformatf("vec%0d_addr", i), imem_addr, vecs[i].e_addr);
            checkOutput($sformatf("vec%0d_fcount", i), fetch_count, vecs[i].e_fc);
            if (vecs[i].e_valid) begin
                checkOutput($sformatf("vec%0d_pc", i), if_pc, vecs[i].e_pc);
                checkOutput($sformatf("vec%0d_instr", i), if_instr, rom_model(vecs[i].e_pc));
                checkOutput($sformatf("vec%0d_plus4", i), if_pc_plus4, vecs[i].e_pc + 32'd4);
            end
            @(negedge clk);
        end

        // Back-pressure: buffer saturates, PC holds at 0x8, then drains in order
        doReset(1'b0);
        @(posedge clk);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp_hold%0d_addr", i), imem_addr, 32'h8);
            checkHead($sformatf("bp_hold%0d", i), 32'h0);
        end
        @(negedge clk);
        if_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checkHead($sformatf("bp_drain%0d", k), 32'(k * 4));
            @(posedge clk);
            #1;
        end
        checkOutput("bp_fcount", fetch_count, 32'd3);

        // Chained redirect: the latest target during FLUSH wins
        doReset(1'b1);
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 32'h14, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 32'h0C, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("chain_flush_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("chain_flush_addr", imem_addr, 32'h0C);
        waitValid("chain");
        checkHead("chain_head", 32'h0C);

        // Redirect near the top of the address space; PC wraps to 0
        @(negedge clk);
        applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b1);
        waitValid("wrap");
        checkHead("wrap_head0", 32'hFFFF_FFF8);
        @(posedge clk);
        #1;
        checkHead("wrap_head1", 32'hFFFF_FFFC);
        checkOutput("wrap_plus4_zero", if_pc_plus4, 32'h0);
        @(posedge clk);
        #1;
        checkHead("wrap_head2", 32'h0);
        @(posedge clk);
        #1;
        checkHead("wrap_head3", 32'h4);

        // Mid-run reset clears outputs without a clock edge
        reset = 1'b1;
        #1;
        checkOutput("async_valid",  {31'd0, if_valid}, 32'd0);
        checkOutput("async_addr",   imem_addr, 32'h0);
        checkOutput("async_instr",  if_instr, 32'h0);
        checkOutput("async_pc",     if_pc, 32'h0);
        checkOutput("async_plus4",  if_pc_plus4, 32'h4);
        checkOutput("async_fcount", fetch_count, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("restart_boot_valid", {31'd0, if_valid}, 32'd0);
        waitValid("restart");
        checkHead("restart_head", 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter FIFO_DEPTH, default 2, fixed at 2: fetch buffer entries. Other values are unsupported.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_addr  output  32  byte address to the combinational instruction ROM; equals the PC register.
REQ-006 imem_instr  input  32  ROM data for imem_addr, valid in the same cycle.
REQ-007 redirect_valid  input  1  branch/jump/exception redirect request from a later stage.
REQ-008 redirect_pc  input  32  redirect target; bits [1:0] ignored and treated as 0.
REQ-009 if_valid  output  1  buffer head holds a valid instruction.
REQ-010 if_ready  input  1  decode accepts the head this cycle.
REQ-011 if_instr  output  32  head instruction.
REQ-012 if_pc  output  32  head instruction address.
REQ-013 if_pc_plus4  output  32  if_pc + 4, modulo 2^32.
REQ-014 fetch_count  output  32  number of accepted instructions, wraps modulo 2^32.

Function
REQ-015 FSM states: BOOT, RUN, FLUSH. After reset the FSM enters BOOT. BOOT goes to RUN after one cycle with no push. RUN goes to FLUSH on redirect_valid. FLUSH goes to RUN after one cycle.
REQ-016 Pop: pop = if_valid && if_ready. fetch_count increments by 1 on each pop.
REQ-017 Push in RUN with no redirect: push = (count < 2) || pop. Push writes {PC, imem_instr} at the tail and sets PC <= PC + 4. PC 32'hFFFF_FFFC wraps to 0.
REQ-018 Push is not performed in BOOT, in FLUSH, or in any cycle with redirect_valid = 1.
REQ-019 Redirect has priority over push and pop. When redirect_valid = 1:
  - all buffer entries are invalidated (count <= 0);
  - PC <= {redirect_pc[31:2], 2'b00};
  - a pop in that cycle is not counted.
REQ-020 A redirect arriving while in FLUSH restarts FLUSH with the new target; the latest redirect wins.
REQ-021 Instruction latency: the PC is presented on imem_addr in cycle N and appears at the head no earlier than cycle N+1 (if_valid = 1).
REQ-022 Full buffer (count = 2) with if_ready = 0: PC holds, imem_addr holds, and if_instr/if_pc stay stable.
REQ-023 Full buffer with pop: push and pop both occur, and count stays 2.
REQ-024 Empty buffer: if_valid = 0 and if_ready is ignored. A push into an empty buffer is visible at the head on the next cycle; there is no bypass.
REQ-025 Sustained throughput is 1 instruction/cycle in RUN with if_ready held high.
REQ-026 if_instr and if_pc are don't-care while if_valid = 0; they are driven from the head entry with no X-propagation.

Reset
REQ-027 Asynchronous reset sets:
  - PC = RESET_PC, so imem_addr = RESET_PC;
  - count = 0, if_valid = 0;
  - if_instr = 0, if_pc = 0, if_pc_plus4 = 4;
  - fetch_count = 0;
  - state = BOOT.
REQ-028 Reset asserted mid-operation discards all buffered entries and any pending redirect immediately, without waiting for a clock edge.
REQ-029 The first push after reset deassertion occurs 2 rising edges after deassertion (one cycle in BOOT).

Structure
REQ-030 The shared package holds:
  - the FSM state enum {BOOT, RUN, FLUSH};
  - constants INSTR_W = 32 and NOP_INSTR = 32'h0000_0000;
  - the buffer entry typedef {pc[31:0], instr[31:0]}.
REQ-031 The 2-entry buffer is a sub-module, fetch_fifo2, with:
  - ports push, pop, flush, din, dout, count;
  - flush having priority over push and pop.
  The FSM, PC and counter stay in imem_fetch_ctrl.

Verification
REQ-032 Reset release with if_ready = 1 -> first instruction at the head is if_pc = 0x0, if_instr = 0x2004_0003. The next head is if_pc = 0x4, if_instr = 0x0C00_0005. Thereafter one instruction per cycle.
REQ-033 if_ready = 0 for 5 cycles after the first push -> count saturates at 2 and imem_addr holds at 0x8. Releasing if_ready delivers 0x0, 0x4, 0x8 in order, with none lost or duplicated.
REQ-034 redirect_valid = 1 with redirect_pc = 0x16 while the buffer is full:
  - next cycle: if_valid = 0, imem_addr = 0x14;
  - after FLUSH: head if_pc = 0x14, if_instr = 0x23BD_FFF8;
  - fetch_count unchanged by the redirect cycle.
REQ-035 Redirect to 0x14, then a second redirect to 0x0C during FLUSH -> the first head after recovery is if_pc = 0x0C, if_instr = 0x1000_FFFF.
REQ-036 redirect_pc = 0xFFFF_FFF8 with if_ready = 1 -> heads are 0xFFFF_FFF8, then 0xFFFF_FFFC, then 0x0. if_pc_plus4 for the 0xFFFF_FFFC head is 0x0.
REQ-037 Assert reset for 1 cycle while if_valid = 1 -> outputs go to their REQ-027 values before the next clock edge, and fetching restarts at RESET_PC.
